// File: rtl/pc_unit_pkg.sv
// Shared encodings for the PC/branch unit: request opcodes, FSM states, default width.
package pc_unit_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_INC    = 2'b00,
    OP_BRANCH = 2'b01,
    OP_JUMP   = 2'b10,
    OP_JAL    = 2'b11
  } req_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_CON = 2'b01,
    ST_UPDATE   = 2'b10
  } state_e;

endpackage

// File: rtl/pc_target_adder.sv
// Combinational next-PC candidates: sequential (pc+1) and relative (pc+1+offset), modulo 2^DATA_WIDTH.
module pc_target_adder
  import pc_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] offset,
  output logic [DATA_WIDTH-1:0] pc_plus1,
  output logic [DATA_WIDTH-1:0] pc_branch
);

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  // Two's-complement offset makes backward branches a plain wrapping add.
  assign pc_plus1  = pc + ONE;
  assign pc_branch = pc_plus1 + offset;

endmodule

// File: rtl/pc_branch_unit.sv
// Program-counter update unit: INC / BRANCH (waits for CON) / JUMP / JAL with link write.
// Optional build macro PC_BRANCH_STATS_EN adds saturating branch_cnt / taken_cnt outputs.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready is
// high only in IDLE, and the request fields are captured on that edge and not looked at again.
module pc_branch_unit
  import pc_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0] jump_target,
  input  logic                  con_in,
  input  logic                  con_valid,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] link_out,
  output logic                  link_we,
  output logic                  taken,
  output logic                  done,
`ifdef PC_BRANCH_STATS_EN
  output logic [15:0]           branch_cnt,
  output logic [15:0]           taken_cnt,
`endif
  output logic [1:0]            state_dbg
);

  state_e                  state_q, state_d;
  req_op_e                 op_q;
  logic [DATA_WIDTH-1:0]   offset_q;
  logic [DATA_WIDTH-1:0]   target_q;
  logic [DATA_WIDTH-1:0]   pc_q;
  logic [DATA_WIDTH-1:0]   link_q;
  logic                    con_q;
  logic                    taken_q;
  logic                    accept;
  logic                    con_sample;
  logic                    is_update;
  logic                    redirect;
  logic [DATA_WIDTH-1:0]   pc_plus1;
  logic [DATA_WIDTH-1:0]   pc_branch;
  logic [DATA_WIDTH-1:0]   pc_next;

  pc_target_adder #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_adder (
    .pc        (pc_q),
    .offset    (offset_q),
    .pc_plus1  (pc_plus1),
    .pc_branch (pc_branch)
  );

  assign accept     = req_valid && (state_q == ST_IDLE);
  assign con_sample = con_valid && (state_q == ST_WAIT_CON);
  assign is_update  = (state_q == ST_UPDATE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (req_op_e'(req_op) == OP_BRANCH) ? ST_WAIT_CON : ST_UPDATE;
        end
      end
      ST_WAIT_CON: begin
        if (con_valid) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_next  = pc_plus1;
    redirect = 1'b0;
    case (op_q)
      OP_INC: begin
        pc_next  = pc_plus1;
        redirect = 1'b0;
      end
      OP_BRANCH: begin
        pc_next  = con_q ? pc_branch : pc_plus1;
        redirect = con_q;
      end
      OP_JUMP, OP_JAL: begin
        pc_next  = target_q;
        redirect = 1'b1;
      end
      default: begin
        pc_next  = pc_plus1;
        redirect = 1'b0;
      end
    endcase
  end

  // Strobes are masked by clear so a reset landing on UPDATE never shows a completion.
  assign req_ready = (state_q == ST_IDLE);
  assign done      = is_update && !clear;
  assign link_we   = is_update && !clear && (op_q == OP_JAL);
  assign pc_out    = pc_q;
  assign link_out  = link_q;
  assign taken     = taken_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_INC;
      offset_q <= '0;
      target_q <= '0;
      pc_q     <= RESET_PC;
      link_q   <= '0;
      con_q    <= 1'b0;
      taken_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= req_op_e'(req_op);
        offset_q <= offset;
        target_q <= jump_target;
        // PC is stable until UPDATE, so the return address can be captured now.
        if (req_op_e'(req_op) == OP_JAL) begin
          link_q <= pc_plus1;
        end
      end
      if (con_sample) begin
        con_q <= con_in;
      end
      if (is_update) begin
        pc_q    <= pc_next;
        taken_q <= redirect;
      end
    end
  end

`ifdef PC_BRANCH_STATS_EN
  logic [15:0] branch_cnt_q;
  logic [15:0] taken_cnt_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else if (is_update && (op_q == OP_BRANCH)) begin
      if (branch_cnt_q != 16'hFFFF) begin
        branch_cnt_q <= branch_cnt_q + 16'd1;
      end
      if (con_q && (taken_cnt_q != 16'hFFFF)) begin
        taken_cnt_q <= taken_cnt_q + 16'd1;
      end
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: reference PC model feeds an expected queue popped on done.
module tb_pc_branch_unit;

  localparam int W = 32;
  localparam logic [W-1:0] RST_PC = 32'h0000_0000;

  logic         clk;
  logic         clear;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] offset;
  logic [W-1:0] jump_target;
  logic         con_in;
  logic         con_valid;
  logic [W-1:0] pc_out;
  logic [W-1:0] link_out;
  logic         link_we;
  logic         taken;
  logic         done;
  logic [1:0]   state_dbg;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0]  branch_cnt;
  logic [15:0]  taken_cnt;
`endif

  pc_branch_unit #(
    .DATA_WIDTH (W),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .offset      (offset),
    .jump_target (jump_target),
    .con_in      (con_in),
    .con_valid   (con_valid),
    .pc_out      (pc_out),
    .link_out    (link_out),
    .link_we     (link_we),
    .taken       (taken),
    .done        (done),
`ifdef PC_BRANCH_STATS_EN
    .branch_cnt  (branch_cnt),
    .taken_cnt   (taken_cnt),
`endif
    .state_dbg   (state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_pc_q[$];
  logic [W-1:0] exp_taken_q[$];
  logic [W-1:0] exp_link_q[$];
  logic [W-1:0] model_pc;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: one request, optional CON wait, then scoreboard compare on done
  task automatic issue(input logic [1:0] op, input logic [W-1:0] off, input logic [W-1:0] tgt,
                       input logic con, input int con_delay);
    logic [W-1:0] pc1;
    logic [W-1:0] e_pc;
    logic         e_tk;
    int           n;
    pc1 = model_pc + 32'd1;
    case (op)
      2'b00:   begin e_pc = pc1;                      e_tk = 1'b0; end
      2'b01:   begin e_pc = con ? pc1 + off : pc1;    e_tk = con;  end
      default: begin e_pc = tgt;                      e_tk = 1'b1; end
    endcase
    exp_pc_q.push_back(e_pc);
    exp_taken_q.push_back({31'd0, e_tk});
    exp_link_q.push_back((op == 2'b11) ? pc1 : 32'd0);

    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid   = 1'b1;
    req_op      = op;
    offset      = off;
    jump_target = tgt;
    con_valid   = 1'b1;        // must be ignored in the acceptance cycle
    con_in      = ~con;
    @(negedge clk);
    req_valid   = 1'b0;
    con_valid   = 1'b0;
    offset      = $urandom;    // latched copies must be used from now on
    jump_target = $urandom;
    req_op      = 2'($urandom_range(0, 3));

    if (op == 2'b01) begin
      for (int i = 0; i < con_delay; i++) begin
        check("wait_ready_low", {31'd0, req_ready}, 32'd0);
        check("wait_no_done", {31'd0, done}, 32'd0);
        @(negedge clk);
      end
      con_valid = 1'b1;
      con_in    = con;
      check("wait_ready_low", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      con_valid = 1'b0;
      con_in    = ~con;
    end

    n = 0;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", n, 0);
    if (done) begin
      check("link_we", {31'd0, link_we}, (op == 2'b11) ? 32'd1 : 32'd0);
      if (op == 2'b11) check("link_out", link_out, exp_link_q[0]);
      void'(exp_link_q.pop_front());
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("link_we_one_cycle", {31'd0, link_we}, 32'd0);
      check("pc_out", pc_out, exp_pc_q.pop_front());
      check("taken", {31'd0, taken}, exp_taken_q.pop_front());
    end else begin
      void'(exp_link_q.pop_front());
      void'(exp_pc_q.pop_front());
      void'(exp_taken_q.pop_front());
    end
    model_pc = e_pc;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    model_pc = RST_PC;
  endtask

  initial begin
    clear       = 1'b1;
    req_valid   = 1'b0;
    req_op      = 2'b00;
    offset      = '0;
    jump_target = '0;
    con_in      = 1'b0;
    con_valid   = 1'b0;
    model_pc    = RST_PC;
    repeat (2) @(negedge clk);
    clear = 1'b0;

    check("rst_pc", pc_out, RST_PC);
    check("rst_link", link_out, 32'd0);
    check("rst_link_we", {31'd0, link_we}, 32'd0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);

    // INC at pc=5
    issue(2'b10, 32'd0, 32'd5, 1'b0, 0);
    issue(2'b00, 32'd0, 32'd0, 1'b0, 0);
    // taken backward branch after a 3-cycle CON wait
    issue(2'b10, 32'd0, 32'd10, 1'b0, 0);
    issue(2'b01, 32'hFFFF_FFFC, 32'd0, 1'b1, 3);
    // not-taken branch
    issue(2'b10, 32'd0, 32'd10, 1'b0, 0);
    issue(2'b01, 32'd20, 32'd0, 1'b0, 1);
    // JAL with link
    issue(2'b10, 32'd0, 32'h40, 1'b0, 0);
    issue(2'b11, 32'd0, 32'h200, 1'b0, 0);
    check("link_hold", link_out, 32'h41);
    // wrap on INC and on a negative branch below zero
    issue(2'b10, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    issue(2'b00, 32'd0, 32'd0, 1'b0, 0);
    issue(2'b01, 32'hFFFF_FFF0, 32'd0, 1'b1, 0);

    // clear while waiting for CON, with con_valid in the same cycle
    issue(2'b10, 32'd0, 32'h30, 1'b0, 0);
    check("ready_pre_branch", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = 2'b01;
    offset    = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("in_wait_con", {30'd0, state_dbg}, 32'd1);
    con_valid = 1'b1;
    con_in    = 1'b1;
    do_clear();
    con_valid = 1'b0;
    check("clr_pc", pc_out, RST_PC);
    check("clr_state", {30'd0, state_dbg}, 32'd0);
    check("clr_ready", {31'd0, req_ready}, 32'd1);
    check("clr_taken", {31'd0, taken}, 32'd0);
    check("clr_link", link_out, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("clr_no_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end

    // random mix against the model
    for (int k = 0; k < 40; k++) begin
      issue(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3));
    end

    check("queue_empty", exp_pc_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
